// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared definitions for the instruction fetch unit: the fetch FSM state
// encoding, the NOP instruction word used to fill empty output slots, the
// default reset fetch address and a small word-alignment helper.
// ---------------------------------------------------------------------------
package ifu_pkg;

  // REQ  : request is being presented to instruction memory
  // WAIT : one request accepted, waiting for its response
  // HOLD : response parked in the skid buffer while downstream is stalled
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction addresses are word aligned; low two bits are forced to zero.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_skid_buf.sv
// ---------------------------------------------------------------------------
// ifu_skid_buf
// Single-entry buffer that parks one fetched {pc, instruction} pair while the
// downstream stage is stalled.
//
// Ports
//   clk       : clock
//   rst_n     : synchronous active-low reset (empties the buffer)
//   load      : capture load_pc/load_inst and mark the entry valid
//   drop      : discard the entry (has priority over load)
//   load_pc   : pc of the instruction being parked
//   load_inst : instruction word being parked
//   valid     : entry holds a parked instruction
//   buf_pc    : parked pc
//   buf_inst  : parked instruction word
// ---------------------------------------------------------------------------
module ifu_skid_buf
  import ifu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        drop,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        valid,
  output logic [31:0] buf_pc,
  output logic [31:0] buf_inst
);

  // Single storage entry; drop wins so a same-cycle load cannot resurrect
  // an entry that the fetch FSM has decided to throw away.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      buf_pc   <= 32'h0000_0000;
      buf_inst <= NOP_INST;
    end else if (drop) begin
      valid    <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      buf_pc   <= load_pc;
      buf_inst <= load_inst;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch unit. Issues one request at a time to instruction
// memory, registers the returned instruction for the IF/DE boundary, parks a
// response in a skid buffer when downstream stalls, and handles redirects
// from execute (jump_en), which take priority over stall.
//
// Ports
//   clk         : clock, all state updates on its rising edge
//   rst_n       : synchronous active-low reset
//   stall       : downstream hold; output registers freeze
//   jump_en     : redirect request, overrides stall
//   jump_addr   : redirect target (low two bits ignored)
//   imem_req    : request valid towards instruction memory
//   imem_addr   : request address (the internal fetch pc)
//   imem_gnt    : request accepted when imem_req && imem_gnt
//   imem_rvalid : response valid (only honoured while waiting for one)
//   imem_rdata  : response instruction word
//   pc          : pc of inst_o
//   inst_o      : fetched instruction, NOP when no valid instruction
//   inst_valid  : inst_o is a real fetched instruction
// ---------------------------------------------------------------------------
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst_o,
  output logic        inst_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         discard_q, discard_d;

  logic         skid_load, skid_drop, skid_valid;
  logic [31:0]  skid_pc, skid_inst;

  logic         load_out;
  logic [31:0]  load_pc, load_inst;
  logic [31:0]  pc_d, inst_d;
  logic         valid_d;
  logic [31:0]  jump_tgt;

  assign jump_tgt  = align_word(jump_addr);
  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = fetch_pc_q;

  ifu_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .drop      (skid_drop),
    .load_pc   (fetch_pc_q),
    .load_inst (imem_rdata),
    .valid     (skid_valid),
    .buf_pc    (skid_pc),
    .buf_inst  (skid_inst)
  );

  // Fetch FSM next-state logic. discard marks the single outstanding request
  // as stale after a redirect so its response is thrown away when it lands.
  // load_out/load_pc/load_inst describe the instruction, if any, that should
  // reach the output registers this cycle.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    skid_load  = 1'b0;
    skid_drop  = 1'b0;
    load_out   = 1'b0;
    load_pc    = fetch_pc_q;
    load_inst  = imem_rdata;

    case (state_q)
      ST_REQ: begin
        if (jump_en) begin
          fetch_pc_d = jump_tgt;
          if (imem_gnt) begin
            // The accepted request is for the old address; mark it stale.
            state_d   = ST_WAIT;
            discard_d = 1'b1;
          end
        end else if (imem_gnt) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (imem_rvalid) begin
          state_d   = ST_REQ;
          discard_d = 1'b0;
          if (jump_en) begin
            fetch_pc_d = jump_tgt;
          end else if (!discard_q) begin
            if (stall) begin
              skid_load = 1'b1;
              state_d   = ST_HOLD;
            end else begin
              load_out   = 1'b1;
              fetch_pc_d = fetch_pc_q + 32'd4;
            end
          end
        end else if (jump_en) begin
          discard_d  = 1'b1;
          fetch_pc_d = jump_tgt;
        end
      end

      ST_HOLD: begin
        if (jump_en) begin
          skid_drop  = 1'b1;
          fetch_pc_d = jump_tgt;
          state_d    = ST_REQ;
        end else if (!skid_valid) begin
          // Empty buffer in HOLD cannot happen in normal operation; recover
          // by resuming fetch at the current address.
          state_d = ST_REQ;
        end else if (!stall) begin
          skid_drop  = 1'b1;
          load_out   = 1'b1;
          load_pc    = skid_pc;
          load_inst  = skid_inst;
          fetch_pc_d = skid_pc + 32'd4;
          state_d    = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // Output register next values: a redirect always empties the slot, a
  // stall freezes it, otherwise it takes the new instruction or a bubble.
  always_comb begin
    pc_d    = pc;
    inst_d  = inst_o;
    valid_d = inst_valid;
    if (jump_en) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (load_out) begin
        pc_d    = load_pc;
        inst_d  = load_inst;
        valid_d = 1'b1;
      end else begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end
    end
  end

  // State and output registers. Reset abandons any outstanding request and
  // restarts fetching at RESET_PC on the first cycle after release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
      pc         <= 32'h0000_0000;
      inst_o     <= NOP_INST;
      inst_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      pc         <= pc_d;
      inst_o     <= inst_d;
      inst_valid <= valid_d;
    end
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset; bits[1:0] SHALL be zero.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk only.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled on posedge clk.
REQ-004 stall  input  1  downstream hold; outputs and fetch progress freeze.
REQ-005 jump_en  input  1  redirect request from execute; priority over stall.
REQ-006 jump_addr  input  32  redirect target; bits[1:0] SHALL be forced to 0.
REQ-007 imem_req  output  1  instruction memory request valid.
REQ-008 imem_addr  output  32  request address, equal to internal fetch_pc.
REQ-009 imem_gnt  input  1  request accepted when imem_req && imem_gnt.
REQ-010 imem_rvalid  input  1  response valid, no back-pressure; at most one outstanding.
REQ-011 imem_rdata  input  32  response instruction word.
REQ-012 pc  output  32  registered PC of inst_o, feeds the IF/DE register.
REQ-013 inst_o  output  32  registered instruction; NOP 32'h0000_0013 when no valid instruction.
REQ-014 inst_valid  output  1  registered; 1 when inst_o is a real fetched instruction.

Function
REQ-015 FSM states SHALL be REQ (imem_req=1), WAIT (one request outstanding, imem_req=0), HOLD (response parked in skid buffer, imem_req=0).
REQ-016 REQ: gnt && !jump_en -> WAIT; !gnt -> stay REQ with imem_addr stable.
REQ-017 REQ with jump_en: !gnt -> stay REQ, fetch_pc<=jump_addr same cycle; gnt -> WAIT, discard<=1, fetch_pc<=jump_addr.
REQ-018 WAIT, rvalid, discard=0, stall=0, !jump_en: pc<=fetch_pc, inst_o<=imem_rdata, inst_valid<=1, fetch_pc<=fetch_pc+4, -> REQ.
REQ-019 WAIT, rvalid, discard=0, stall=1: {fetch_pc, rdata} SHALL be written to skid buffer, -> HOLD; outputs hold.
REQ-020 WAIT, rvalid, discard=1: response dropped, discard<=0, -> REQ at current fetch_pc.
REQ-021 WAIT, jump_en, no rvalid: discard<=1, fetch_pc<=jump_addr, stay WAIT; jump_en with rvalid: response dropped, -> REQ at jump_addr.
REQ-022 HOLD, stall=0: buffer moves to pc/inst_o, inst_valid<=1, fetch_pc<=buffered pc+4, -> REQ; stall=1: stay.
REQ-023 HOLD, jump_en: buffer dropped, fetch_pc<=jump_addr, -> REQ.
REQ-024 Any cycle with jump_en: next cycle inst_valid=0, inst_o=NOP, pc holds, regardless of stall.
REQ-025 stall=1 and !jump_en: pc, inst_o, inst_valid SHALL hold; a request already in REQ MAY still be granted.
REQ-026 stall=0, no new instruction loaded: inst_valid<=0, inst_o<=NOP, pc holds.
REQ-027 fetch_pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-028 imem_rvalid outside WAIT is a protocol error and SHALL be ignored.
REQ-029 Best-case throughput: one instruction per 2 cycles with single-cycle gnt and rvalid one cycle after grant.

Reset
REQ-030 rst_n=0 at posedge: state<=REQ, fetch_pc<=RESET_PC, discard<=0, skid buffer empty, pc<=0, inst_o<=NOP, inst_valid<=0.
REQ-031 Reset mid-transaction SHALL abandon the outstanding request; first cycle after release SHALL drive imem_req=1, imem_addr=RESET_PC.
REQ-032 A response arriving in the first WAIT after reset belongs to the new request only.

Structure
REQ-033 Shared package ifu_pkg SHALL hold FSM state encoding, NOP constant 32'h0000_0013, and default RESET_PC.
REQ-034 One sub-module ifu_skid_buf: single-entry {pc, inst} buffer with load, drop, valid; synchronous active-low reset.
REQ-035 Outputs pc, inst_o, inst_valid SHALL be driven directly from flops; imem_req/imem_addr decoded from state and fetch_pc.

Verification
REQ-036 Reset, gnt=1, rvalid 1 cycle after grant, rdata=addr^32'hA5A5_0000: pc sequence 0,4,8 with inst_valid every 2nd cycle.
REQ-037 gnt held low 3 cycles at address 0x10: imem_addr stays 0x10, single request granted, inst_o matches 0x10 data.
REQ-038 stall=1 when response for 0x20 arrives, held 4 cycles: outputs frozen, HOLD entered, on release pc=0x20, next req 0x24.
REQ-039 jump_en with jump_addr=0x103 while WAIT: stale response dropped, inst_valid=0 next cycle, next req addr 0x100.
REQ-040 jump_en and rvalid same cycle, plus jump in HOLD: both responses discarded, fetch resumes at jump target.
REQ-041 RESET_PC=32'hFFFF_FFFC, rst_n low mid-WAIT: after release req 0xFFFF_FFFC, then 0x0000_0000.
